// File: rtl/vidac_arbiter.sv
// vidac_arbiter: shares the single-port 256Kx8 video RAM between the CPU and the vidac
// drawing accelerator, and sequences accelerator runs.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   cpu_a/cpu_o/cpu_w     CPU address, write data, write strobe (valid with cpu_req)
//   cpu_req/cpu_rdy       CPU access request / accepted this cycle
//   cpu_i                 CPU read data (RAM read data)
//   cpu_go                one-cycle request to start an accelerator run
//   stat_clr              clears the sticky error flags
//   vd_a/vd_o/vd_w        accelerator address, write data, write strobe
//   vd_bsy                accelerator busy
//   vd_i                  accelerator read data (RAM read data)
//   vd_cmd                accelerator start pulse
//   vd_rst_n              accelerator reset, active-low
//   mem_a/mem_o/mem_w     RAM address, write data, write enable
//   mem_i                 RAM read data, one-cycle synchronous read
//   busy, done            run in progress, one-cycle completion pulse
//   err_ovf, err_to       sticky flags: start request overflow, watchdog abort
module vidac_arbiter #(
  parameter int unsigned TOW = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [17:0] cpu_a,
  input  logic [7:0]  cpu_o,
  input  logic        cpu_w,
  input  logic        cpu_req,
  output logic        cpu_rdy,
  output logic [7:0]  cpu_i,
  input  logic        cpu_go,
  input  logic        stat_clr,
  input  logic [17:0] vd_a,
  input  logic [7:0]  vd_o,
  input  logic        vd_w,
  input  logic        vd_bsy,
  output logic [7:0]  vd_i,
  output logic        vd_cmd,
  output logic        vd_rst_n,
  output logic [17:0] mem_a,
  output logic [7:0]  mem_o,
  output logic        mem_w,
  input  logic [7:0]  mem_i,
  output logic        busy,
  output logic        done,
  output logic        err_ovf,
  output logic        err_to
);

  typedef enum logic [2:0] {
    StIdle,
    StKick,
    StArm,
    StRun,
    StDone,
    StAbort
  } state_e;

  localparam logic [TOW-1:0] WdMax = '1;
  localparam logic [TOW-1:0] WdOne = {{(TOW-1){1'b0}}, 1'b1};

  state_e         state_q, state_d;
  logic           own_q, own_d;
  logic           pend_q, pend_d;
  logic [TOW-1:0] wd_q, wd_d;
  logic           abort_cnt_q, abort_cnt_d;
  logic           vd_cmd_q, vd_cmd_d;
  logic           vd_rst_n_q, vd_rst_n_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           err_ovf_q, err_ovf_d;
  logic           err_to_q, err_to_d;

  logic           err_ovf_set, err_to_set;
  logic [TOW-1:0] wd_inc;
  logic           wd_expire;

  // Saturating watchdog; expiry is flagged when the count about to be stored reaches
  // all-ones, so ABORT is entered exactly 2^TOW-1 cycles after ARM entry.
  assign wd_inc    = (wd_q == WdMax) ? wd_q : wd_q + WdOne;
  assign wd_expire = (wd_inc == WdMax);

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    wd_d        = wd_q;
    abort_cnt_d = abort_cnt_q;
    err_ovf_set = 1'b0;
    err_to_set  = 1'b0;

    // A start request during a run is queued once; a second one is dropped and flagged.
    if (cpu_go && (state_q != StIdle)) begin
      pend_d = 1'b1;
      if (pend_q) begin
        err_ovf_set = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (cpu_go || pend_q) begin
          state_d = StKick;
          pend_d  = 1'b0;
        end
      end
      StKick: begin
        wd_d    = '0;
        state_d = StArm;
      end
      StArm: begin
        wd_d = wd_inc;
        if (vd_bsy) begin
          state_d = StRun;
        end else if (wd_expire) begin
          state_d     = StAbort;
          abort_cnt_d = 1'b0;
          err_to_set  = 1'b1;
        end
      end
      StRun: begin
        wd_d = wd_inc;
        if (!vd_bsy) begin
          state_d = StDone;
        end else if (wd_expire) begin
          state_d     = StAbort;
          abort_cnt_d = 1'b0;
          err_to_set  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StAbort: begin
        // An aborted run discards any queued start.
        pend_d = 1'b0;
        if (abort_cnt_q) begin
          state_d = StIdle;
        end else begin
          abort_cnt_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    err_ovf_d = err_ovf_set | (err_ovf_q & ~stat_clr);
    err_to_d  = err_to_set | (err_to_q & ~stat_clr);

    // Control outputs are registered by decoding the next state.
    own_d      = (state_d != StIdle);
    busy_d     = (state_d != StIdle);
    vd_cmd_d   = (state_d == StKick);
    done_d     = (state_d == StDone);
    vd_rst_n_d = (state_d != StAbort);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      own_q       <= 1'b0;
      pend_q      <= 1'b0;
      wd_q        <= '0;
      abort_cnt_q <= 1'b0;
      vd_cmd_q    <= 1'b0;
      vd_rst_n_q  <= 1'b1;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      pend_q      <= pend_d;
      wd_q        <= wd_d;
      abort_cnt_q <= abort_cnt_d;
      vd_cmd_q    <= vd_cmd_d;
      vd_rst_n_q  <= vd_rst_n_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      err_ovf_q   <= err_ovf_d;
      err_to_q    <= err_to_d;
    end
  end

  // Bus mux follows the registered owner bit only.
  always_comb begin
    if (own_q) begin
      mem_a   = vd_a;
      mem_o   = vd_o;
      mem_w   = vd_w;
      cpu_rdy = 1'b0;
    end else begin
      mem_a   = cpu_a;
      mem_o   = cpu_o;
      mem_w   = cpu_req & cpu_w;
      cpu_rdy = 1'b1;
    end
  end

  assign cpu_i    = mem_i;
  assign vd_i     = mem_i;
  assign vd_cmd   = vd_cmd_q;
  assign vd_rst_n = vd_rst_n_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign err_ovf  = err_ovf_q;
  assign err_to   = err_to_q;

endmodule

// File: tb/tb_vidac_arbiter.sv
// Self-checking bench for vidac_arbiter with a behavioural 256Kx8 synchronous RAM.
// Accelerator behaviour is driven cycle by cycle from the test tasks.
module tb_vidac_arbiter;

  localparam int unsigned TOW = 6;

  logic        clock = 1'b0;
  logic        reset;
  logic [17:0] cpu_a;
  logic [7:0]  cpu_o;
  logic        cpu_w;
  logic        cpu_req;
  logic        cpu_rdy;
  logic [7:0]  cpu_i;
  logic        cpu_go;
  logic        stat_clr;
  logic [17:0] vd_a;
  logic [7:0]  vd_o;
  logic        vd_w;
  logic        vd_bsy;
  logic [7:0]  vd_i;
  logic        vd_cmd;
  logic        vd_rst_n;
  logic [17:0] mem_a;
  logic [7:0]  mem_o;
  logic        mem_w;
  logic [7:0]  mem_i;
  logic        busy;
  logic        done;
  logic        err_ovf;
  logic        err_to;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_rd[$];
  logic [25:0] exp_wr[$];
  logic [7:0]  ram [0:262143];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_w) ram[mem_a] <= mem_o;
    mem_i <= ram[mem_a];
  end

  vidac_arbiter #(.TOW(TOW)) dut (
    .clock   (clock),
    .reset   (reset),
    .cpu_a   (cpu_a),
    .cpu_o   (cpu_o),
    .cpu_w   (cpu_w),
    .cpu_req (cpu_req),
    .cpu_rdy (cpu_rdy),
    .cpu_i   (cpu_i),
    .cpu_go  (cpu_go),
    .stat_clr(stat_clr),
    .vd_a    (vd_a),
    .vd_o    (vd_o),
    .vd_w    (vd_w),
    .vd_bsy  (vd_bsy),
    .vd_i    (vd_i),
    .vd_cmd  (vd_cmd),
    .vd_rst_n(vd_rst_n),
    .mem_a   (mem_a),
    .mem_o   (mem_o),
    .mem_w   (mem_w),
    .mem_i   (mem_i),
    .busy    (busy),
    .done    (done),
    .err_ovf (err_ovf),
    .err_to  (err_to)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (vd_cmd !== 1'b0) begin n_fail++; $display("FAIL reset_vd_cmd: got %b want 0", vd_cmd); end
    n_checks++; if (vd_rst_n !== 1'b1) begin n_fail++; $display("FAIL reset_vd_rst_n: got %b want 1", vd_rst_n); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_err_ovf: got %b want 0", err_ovf); end
    n_checks++; if (err_to !== 1'b0) begin n_fail++; $display("FAIL reset_err_to: got %b want 0", err_to); end
    n_checks++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_rdy: got %b want 1", cpu_rdy); end
  endtask

  task automatic test_cpu_rw();
    logic [7:0] e;
    cpu_req = 1'b1; cpu_w = 1'b1; cpu_a = 18'h00100; cpu_o = 8'h5A;
    #1;
    n_checks++; if (mem_w !== 1'b1) begin n_fail++; $display("FAIL rw_mem_w_wr: got %b want 1", mem_w); end
    n_checks++; if (mem_a !== 18'h00100) begin n_fail++; $display("FAIL rw_mem_a: got %h want 00100", mem_a); end
    n_checks++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL rw_rdy_wr: got %b want 1", cpu_rdy); end
    cyc();
    cpu_w = 1'b0;
    exp_rd.push_back(8'h5A);
    #1;
    n_checks++; if (mem_w !== 1'b0) begin n_fail++; $display("FAIL rw_mem_w_rd: got %b want 0", mem_w); end
    n_checks++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL rw_rdy_rd: got %b want 1", cpu_rdy); end
    cyc();
    cpu_req = 1'b0;
    e = (exp_rd.size() > 0) ? exp_rd.pop_front() : 8'hxx;
    n_checks++; if (cpu_i !== e) begin n_fail++; $display("FAIL rw_read: got %h want %h", cpu_i, e); end
  endtask

  // Run of 50 busy cycles, with a CPU read accepted in the same cycle as cpu_go.
  task automatic test_run();
    logic [7:0] e;
    cpu_go = 1'b1; cpu_req = 1'b1; cpu_w = 1'b0; cpu_a = 18'h00100;
    #1;
    n_checks++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL run_rdy_go: got %b want 1", cpu_rdy); end
    exp_rd.push_back(8'h5A);
    cyc();
    cpu_go = 1'b0; cpu_req = 1'b0;
    e = (exp_rd.size() > 0) ? exp_rd.pop_front() : 8'hxx;
    n_checks++; if (cpu_i !== e) begin n_fail++; $display("FAIL run_read_kick: got %h want %h", cpu_i, e); end
    n_checks++; if (vd_cmd !== 1'b1) begin n_fail++; $display("FAIL run_cmd_kick: got %b want 1", vd_cmd); end
    n_checks++; if (cpu_rdy !== 1'b0) begin n_fail++; $display("FAIL run_rdy_kick: got %b want 0", cpu_rdy); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL run_busy_kick: got %b want 1", busy); end
    cyc();
    vd_bsy = 1'b1;
    n_checks++; if (vd_cmd !== 1'b0) begin n_fail++; $display("FAIL run_cmd_arm: got %b want 0", vd_cmd); end
    for (int i = 0; i < 49; i++) begin
      cyc();
      n_checks++;
      if (vd_cmd !== 1'b0 || cpu_rdy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL run_hold[%0d]: got cmd=%b rdy=%b done=%b want 0 0 0", i, vd_cmd, cpu_rdy, done);
      end
    end
    cyc();
    vd_bsy = 1'b0;
    cyc();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL run_done: got %b want 1", done); end
    n_checks++; if (cpu_rdy !== 1'b0) begin n_fail++; $display("FAIL run_rdy_done: got %b want 0", cpu_rdy); end
    cyc();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL run_done_pulse: got %b want 0", done); end
    n_checks++; if (cpu_rdy !== 1'b1) begin n_fail++; $display("FAIL run_rdy_idle: got %b want 1", cpu_rdy); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL run_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_pend();
    cpu_go = 1'b1; cyc();
    cpu_go = 1'b0; cyc();
    vd_bsy = 1'b1; cyc();
    cpu_go = 1'b1; cyc();
    cpu_go = 1'b0;
    n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL pend_first_ovf: got %b want 0", err_ovf); end
    cyc();
    cpu_go = 1'b1; cyc();
    cpu_go = 1'b0;
    n_checks++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL pend_second_ovf: got %b want 1", err_ovf); end
    vd_bsy = 1'b0;
    cyc();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL pend_done1: got %b want 1", done); end
    cyc();
    n_checks++; if (busy !== 1'b0 || vd_cmd !== 1'b0) begin
      n_fail++; $display("FAIL pend_idle_gap: got busy=%b cmd=%b want 0 0", busy, vd_cmd);
    end
    cyc();
    n_checks++; if (vd_cmd !== 1'b1) begin n_fail++; $display("FAIL pend_rekick: got %b want 1", vd_cmd); end
    cyc();
    vd_bsy = 1'b1; cyc();
    vd_bsy = 1'b0; cyc();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL pend_done2: got %b want 1", done); end
    cyc(); cyc();
    n_checks++; if (vd_cmd !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL pend_no_third: got cmd=%b busy=%b want 0 0", vd_cmd, busy);
    end
    n_checks++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL pend_ovf_sticky: got %b want 1", err_ovf); end
    stat_clr = 1'b1; cyc();
    stat_clr = 1'b0;
    n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL pend_clr: got %b want 0", err_ovf); end
  endtask

  // Accelerator never raises bsy; ARM is entered at N+2, ABORT at N+2+63.
  task automatic test_watchdog();
    cpu_go = 1'b1; cyc();
    cpu_go = 1'b0;
    for (int i = 2; i <= 64; i++) begin
      cyc();
      cpu_go = (i == 10);
    end
    n_checks++; if (vd_rst_n !== 1'b1 || err_to !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL wd_pre: got rst_n=%b err_to=%b busy=%b want 1 0 1", vd_rst_n, err_to, busy);
    end
    cyc();
    n_checks++; if (vd_rst_n !== 1'b0) begin n_fail++; $display("FAIL wd_rst1: got %b want 0", vd_rst_n); end
    n_checks++; if (err_to !== 1'b1) begin n_fail++; $display("FAIL wd_err_to: got %b want 1", err_to); end
    cyc();
    n_checks++; if (vd_rst_n !== 1'b0) begin n_fail++; $display("FAIL wd_rst2: got %b want 0", vd_rst_n); end
    cyc();
    n_checks++; if (vd_rst_n !== 1'b1) begin n_fail++; $display("FAIL wd_rst_end: got %b want 1", vd_rst_n); end
    n_checks++; if (busy !== 1'b0 || cpu_rdy !== 1'b1) begin
      n_fail++; $display("FAIL wd_idle: got busy=%b rdy=%b want 0 1", busy, cpu_rdy);
    end
    cyc();
    n_checks++; if (vd_cmd !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL wd_pend_cleared: got cmd=%b busy=%b want 0 0", vd_cmd, busy);
    end
    stat_clr = 1'b1; cyc();
    stat_clr = 1'b0;
    n_checks++; if (err_to !== 1'b0) begin n_fail++; $display("FAIL wd_clr: got %b want 0", err_to); end
  endtask

  // CPU holds a write across a run; only the vidac write may reach the RAM while stalled.
  task automatic test_cpu_stall();
    int accepted;
    int nwr;
    logic [25:0] e;
    accepted = -1;
    nwr = 0;
    cpu_go = 1'b1; cyc();
    cpu_go = 1'b0; cyc();
    exp_wr.push_back({18'h00300, 8'h77});
    exp_wr.push_back({18'h00200, 8'hC3});
    cpu_req = 1'b1; cpu_w = 1'b1; cpu_a = 18'h00200; cpu_o = 8'hC3;
    vd_a = 18'h00300; vd_o = 8'h77;
    for (int i = 2; i <= 13; i++) begin
      vd_bsy = (i < 9);
      vd_w   = (i == 5);
      if (accepted >= 0) cpu_req = 1'b0;
      #1;
      if (mem_w) begin
        nwr++;
        e = (exp_wr.size() > 0) ? exp_wr.pop_front() : 26'hx;
        n_checks++;
        if ({mem_a, mem_o} !== e) begin
          n_fail++; $display("FAIL stall_write[%0d]: got %h/%h want %h/%h", i, mem_a, mem_o, e[25:8], e[7:0]);
        end
      end
      if (cpu_req && cpu_rdy && accepted < 0) accepted = i;
      cyc();
    end
    cpu_req = 1'b0; cpu_w = 1'b0; vd_w = 1'b0;
    n_checks++; if (accepted != 11) begin n_fail++; $display("FAIL stall_accept_cycle: got %0d want 11", accepted); end
    n_checks++; if (nwr != 2) begin n_fail++; $display("FAIL stall_write_count: got %0d want 2", nwr); end
    n_checks++; if (exp_wr.size() != 0) begin
      n_fail++; $display("FAIL stall_pending_writes: got %0d want 0", exp_wr.size());
    end
  endtask

  task automatic test_reset_mid_run();
    cpu_go = 1'b1; cyc();
    cpu_go = 1'b0; cyc();
    vd_bsy = 1'b1; cyc();
    cpu_go = 1'b1; cyc();
    cpu_go = 1'b0; cyc();
    cpu_go = 1'b1; cyc();
    cpu_go = 1'b0;
    n_checks++; if (err_ovf !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: got ovf=%b busy=%b want 1 1", err_ovf, busy);
    end
    reset = 1'b1; cyc();
    n_checks++; if (busy !== 1'b0 || cpu_rdy !== 1'b1 || vd_cmd !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_ctl: got busy=%b rdy=%b cmd=%b want 0 1 0", busy, cpu_rdy, vd_cmd);
    end
    n_checks++; if (err_ovf !== 1'b0 || err_to !== 1'b0 || done !== 1'b0 || vd_rst_n !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_flags: got ovf=%b to=%b done=%b rst_n=%b want 0 0 0 1",
                         err_ovf, err_to, done, vd_rst_n);
    end
    reset = 1'b0; vd_bsy = 1'b0;
    cyc(); cyc();
    n_checks++; if (vd_cmd !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_pend_cleared: got cmd=%b busy=%b want 0 0", vd_cmd, busy);
    end
  endtask

  initial begin
    reset = 1'b1; cpu_a = '0; cpu_o = '0; cpu_w = 1'b0; cpu_req = 1'b0; cpu_go = 1'b0;
    stat_clr = 1'b0; vd_a = '0; vd_o = '0; vd_w = 1'b0; vd_bsy = 1'b0;
    test_reset();
    test_cpu_rw();
    test_run();
    test_pend();
    test_watchdog();
    test_cpu_stall();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
